// File: rtl/recomp_result_collector.sv
// recomp_result_collector
//   Last stage of the two-digit mixed-radix recomposition pipeline
//   (moduli MOD0 = 65536, MOD1 = 78125). The recomposition chain in front
//   of this block has a fixed latency and no valid or stall signal of its own.
//   This block keeps a RECOMP_LAT-deep copy of in_valid so it knows which
//   cycles carry real digits. It captures those digits, converts the pair
//   to a signed two's-complement word, and buffers the result in a small
//   first-word-fallthrough FIFO.
//
// Ports
//   clk          clock
//   rst_n        synchronous reset, active low
//   in_valid     digits were launched into the recomposition chain this cycle
//   norm_dig_0_  recomposed digit mod MOD0 (valid RECOMP_LAT cycles after in_valid)
//   norm_dig_1_  recomposed digit mod MOD1 (valid RECOMP_LAT cycles after in_valid)
//   out_valid    out_data holds a result
//   out_ready    consumer accepts out_data this cycle
//   out_data     signed result, OUT_WIDTH bits
//   out_err      range-error tag travelling with out_data
//   fifo_level   FIFO occupancy, 0..FIFO_DEPTH
//   overflow     sticky: a result was dropped because the FIFO was full
//   drop_count   saturating count of dropped results
//
// Handshake: a word transfers on any cycle with out_valid && out_ready.
//   While out_valid && !out_ready, out_data and out_err hold their values.
//   out_valid drops only after a transfer, or on reset. Upstream cannot be
//   stalled, so a result that arrives while the FIFO is full and no word is
//   read in that cycle is dropped and counted.
//
// Optional build macro: RECOMP_RANGE_CHK_EN
//   When defined, each digit is compared against its modulus using its full
//   width. The resulting error flag is stored with the word and shown on
//   out_err. When not defined, out_err is 0 and the upper digit bits are
//   ignored.

module recomp_result_collector #(
   parameter int DATA_WIDTH = 18,
   parameter int RECOMP_LAT = 18,
   parameter int MOD0       = 65536,
   parameter int MOD1       = 78125,
   parameter int OUT_WIDTH  = 34,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [DATA_WIDTH-1:0]         norm_dig_0_,
   input  logic [DATA_WIDTH-1:0]         norm_dig_1_,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [OUT_WIDTH-1:0]          out_data,
   output logic                          out_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic [15:0]                   drop_count
);

   localparam int          D0W    = $clog2(MOD0);
   localparam int          D1W    = $clog2(MOD1);
   localparam int          AW     = $clog2(FIFO_DEPTH);
   localparam logic [63:0] M_L    = 64'(MOD0) * 64'(MOD1);
   localparam logic [63:0] HALF_M = M_L >> 1;

   // ---------------------------------------------------------------
   // Valid delay line. The bit vector is one bit wider than the line,
   // so the same code works when RECOMP_LAT is 1.
   // ---------------------------------------------------------------
   logic [RECOMP_LAT-1:0] vld_q;
   logic [RECOMP_LAT:0]   vld_d;
   logic                  v_d;

   assign vld_d = {vld_q, in_valid};
   assign v_d   = vld_q[RECOMP_LAT-1];

   always_ff @(posedge clk) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_d[RECOMP_LAT-1:0];
   end

   // ---------------------------------------------------------------
   // Capture and convert. V = d1*MOD0 + d0 is computed in 64 bits.
   // The upper half of the range folds to negative values: S = V - M.
   // Truncating the 64-bit difference to OUT_WIDTH gives the
   // sign-extended result.
   // ---------------------------------------------------------------
   logic [63:0]          v_val;
   logic [OUT_WIDTH-1:0] cap_data_d;
   logic [OUT_WIDTH-1:0] cap_data_q;
   logic                 cap_vld_q;

   always_comb begin
      v_val      = 64'(norm_dig_1_[D1W-1:0]) * 64'(MOD0) + 64'(norm_dig_0_[D0W-1:0]);
      cap_data_d = (v_val >= HALF_M) ? OUT_WIDTH'(v_val - M_L) : OUT_WIDTH'(v_val);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cap_vld_q  <= 1'b0;
         cap_data_q <= '0;
      end else begin
         cap_vld_q <= v_d;
         if (v_d) cap_data_q <= cap_data_d;
      end
   end

   // ---------------------------------------------------------------
   // Output FIFO (first-word fallthrough).
   // ---------------------------------------------------------------
   logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [AW:0]          count_q, count_d;
   logic                 overflow_q;
   logic [15:0]          drop_cnt_q, drop_cnt_d;
   logic                 full, rd_en, wr_en, drop;

   assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
   assign rd_en = out_valid & out_ready;
   // When the FIFO is full, a read in the same cycle frees the slot that
   // the write then reuses.
   assign wr_en = cap_vld_q & (~full | rd_en);
   assign drop  = cap_vld_q & full & ~rd_en;

   always_comb begin
      count_d = count_q;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
         if (drop) overflow_q <= 1'b1;
      end
   end

   // The storage array is not reset. out_data is forced to zero whenever
   // the FIFO is empty, so stale entries never appear on the output.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= cap_data_q;
   end

   assign out_valid  = (count_q != '0);
   assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_level = count_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_cnt_q;

`ifdef RECOMP_RANGE_CHK_EN
   logic                  cap_err_d, cap_err_q;
   logic [FIFO_DEPTH-1:0] err_mem_q;

   assign cap_err_d = (64'(norm_dig_0_) >= 64'(MOD0)) || (64'(norm_dig_1_) >= 64'(MOD1));

   always_ff @(posedge clk) begin
      if (!rst_n)   cap_err_q <= 1'b0;
      else if (v_d) cap_err_q <= cap_err_d;
   end

   always_ff @(posedge clk) begin
      if (wr_en) err_mem_q[wr_ptr_q] <= cap_err_q;
   end

   assign out_err = out_valid & err_mem_q[rd_ptr_q];
`else
   // Without the range check, the bits above each digit's modulus width
   // carry no meaning.
   logic unused_hi_bits;
   assign unused_hi_bits = ^{norm_dig_0_[DATA_WIDTH-1:D0W], norm_dig_1_[DATA_WIDTH-1:D1W]};
   assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_recomp_result_collector.sv
// Testbench for recomp_result_collector.
// A model of the upstream recomposition chain delays the launched digits by
// RECOMP_LAT cycles. The driver pushes the hand-computed expected words into
// exp_q. A monitor runs on the falling edge, pops one entry per transfer, and
// compares it with the output. It also checks that out_data stays stable
// while the consumer stalls.

module tb_recomp_result_collector;

   localparam int L  = 18;
   localparam int OW = 34;

`ifdef RECOMP_RANGE_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [17:0]   norm_dig_0_ = '0;
   logic [17:0]   norm_dig_1_ = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [OW-1:0] out_data;
   logic          out_err;
   logic [3:0]    fifo_level;
   logic          overflow;
   logic [15:0]   drop_count;

   logic [17:0]   op_d0 = '0;
   logic [17:0]   op_d1 = '0;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [OW:0]   exp_q[$];   // {err, data}

   recomp_result_collector dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .norm_dig_0_ (norm_dig_0_),
      .norm_dig_1_ (norm_dig_1_),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_err     (out_err),
      .fifo_level  (fifo_level),
      .overflow    (overflow),
      .drop_count  (drop_count)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1);
   end

   // ---------------- upstream chain model ----------------
   initial begin : chain
      logic [17:0] p0 [L];
      logic [17:0] p1 [L];
      logic [17:0] s0, s1;
      for (int i = 0; i < L; i++) begin
         p0[i] = '0;
         p1[i] = '0;
      end
      forever begin
         @(posedge clk);
         s0 = in_valid ? op_d0 : 18'h0;
         s1 = in_valid ? op_d1 : 18'h0;
         #1;
         for (int i = L-1; i > 0; i--) begin
            p0[i] = p0[i-1];
            p1[i] = p1[i-1];
         end
         p0[0] = s0;
         p1[0] = s1;
         norm_dig_0_ = p0[L-1];
         norm_dig_1_ = p1[L-1];
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one operand during the current cycle. Returns at the start of
   // the next cycle.
   task automatic issue(input logic [17:0] d0, input logic [17:0] d1, input bit push,
                        input logic [OW-1:0] exp_data, input logic exp_err);
      in_valid = 1'b1;
      op_d0    = d0;
      op_d1    = d1;
      if (push) exp_q.push_back({exp_err, exp_data});
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_out_valid"},  out_valid, 0);
      check({tag, "_out_data"},   $signed(out_data), 0);
      check({tag, "_out_err"},    out_err, 0);
      check({tag, "_fifo_level"}, fifo_level, 0);
      check({tag, "_overflow"},   overflow, 0);
      check({tag, "_drop_count"}, drop_count, 0);
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin : monitor
      logic          hold;
      logic [OW-1:0] hd;
      logic          he;
      logic [OW:0]   e;
      hold = 1'b0;
      hd   = '0;
      he   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               check("hold_valid", out_valid, 1);
               check("hold_data", $signed(out_data), $signed(hd));
               check("hold_err", out_err, he);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_word: got %0d expected no word", $signed(out_data));
               end else begin
                  e = exp_q.pop_front();
                  check("word_data", $signed(out_data), $signed(e[OW-1:0]));
                  check("word_err", out_err, e[OW]);
               end
            end
            hold = out_valid && !out_ready;
            hd   = out_data;
            he   = out_err;
         end
      end
   end

   // ---------------- directed vectors ----------------
   logic [17:0]   vec_d0  [6] = '{18'd0, 18'd65535, 18'd32768, 18'd32767, 18'd65536, 18'd0};
   logic [17:0]   vec_d1  [6] = '{18'd1, 18'd78124, 18'd39062, 18'd39062, 18'd0,     18'd131073};
   logic [OW-1:0] vec_exp [6] = '{34'sd65536, -34'sd1, -34'sd2560000000, 34'sd2559999999,
                                  34'sd0, 34'sd65536};
   logic          vec_err [6] = '{1'b0, 1'b0, 1'b0, 1'b0, CHK, CHK};

   // ---------------- main sequence ----------------
   initial begin : main
      int lat;
      int cnt;

      // Reset
      rst_n = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Single operation: check latency and value
      out_ready = 1'b1;
      issue(18'd5, 18'd0, 1'b1, 34'sd5, 1'b0);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         if (out_valid) begin
            lat = k;
            break;
         end
         tick();
      end
      check("single_latency", lat, L + 2);
      wait_drain(10);

      // Directed conversion vectors, including the +/- M/2 boundary and
      // digits with high bits set
      for (int i = 0; i < 6; i++) issue(vec_d0[i], vec_d1[i], 1'b1, vec_exp[i], vec_err[i]);
      wait_drain(L + 20);
      repeat (2) tick();
      check("idle_out_valid", out_valid, 0);

      // Overflow: 20 back-to-back operations with the consumer stalled
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++)
         issue(18'(100 + i), 18'd0, (i < 8), OW'(100 + i), 1'b0);
      repeat (L + 4) tick();
      check("ovf_fifo_level", fifo_level, 8);
      check("ovf_overflow", overflow, 1);
      check("ovf_drop_count", drop_count, 12);
      check("ovf_out_valid", out_valid, 1);

      // FIFO full: one read and one write in the same cycle
      issue(18'd999, 18'd0, 1'b1, 34'sd999, 1'b0);
      repeat (L) tick();           // now in the cycle where capture is valid
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("fullrw_fifo_level", fifo_level, 8);
      check("fullrw_drop_count", drop_count, 12);
      check("fullrw_overflow", overflow, 1);

      // Drain: 8 words on 8 consecutive cycles
      out_ready = 1'b1;
      cnt = 0;
      while (exp_q.size() > 0 && cnt < 30) begin
         tick();
         cnt++;
      end
      check("drain_cycles", cnt, 8);
      check("drain_out_valid", out_valid, 0);
      check("drain_fifo_level", fifo_level, 0);

      // Reset while operations are buffered and in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) issue(18'(200 + i), 18'd0, 1'b0, '0, 1'b0);
      repeat (L + 3) tick();
      check("pre_rst_fifo_level", fifo_level, 3);
      for (int i = 0; i < 5; i++) issue(18'(300 + i), 18'd0, 1'b0, '0, 1'b0);
      repeat (2) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_all_zero("midrst");
      out_ready = 1'b1;
      repeat (L + 8) tick();
      check("post_rst_out_valid", out_valid, 0);
      check("post_rst_fifo_level", fifo_level, 0);
      check("post_rst_queue", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/recomp_result_collector.md
Name: recomp_result_collector

Overview:
- Downstream stage of the two-digit mixed-radix recomposition pipeline (moduli 65536 and 78125).
- Tracks which launched operands are in flight through the fixed-latency recomposition chain. That chain has no valid or stall of its own.
- Captures norm_dig_0_/norm_dig_1_ when the matching result emerges and converts the pair to a signed two's-complement binary word.
- Buffers results in a small FIFO with a ready/valid output toward the TPU result path.

Parameters:
- DATA_WIDTH, 18, width of each normalized digit input.
- RECOMP_LAT, 18, cycles from the mr_dig launch (in_valid high) to the matching norm_dig_* being valid at this block's inputs; must be >= 1.
- MOD0, 65536, modulus of norm_dig_0_.
- MOD1, 78125, modulus of norm_dig_1_; total range M = MOD0*MOD1 = 5,120,000,000.
- OUT_WIDTH, 34, signed output width; must hold ±M/2.
- FIFO_DEPTH, 8, output FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active low.
- in_valid  in  1  high in the cycle the recomposition digits mr_dig_2_ are launched.
- norm_dig_0_  in  DATA_WIDTH  recomposed digit mod MOD0.
- norm_dig_1_  in  DATA_WIDTH  recomposed digit mod MOD1.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  OUT_WIDTH  signed result.
- out_err  out  1  range error tag for out_data (see Optional Feature).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.
- drop_count  out  16  saturating count of dropped results.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears:
  - the valid delay line and capture stage;
  - the FIFO pointers, so fifo_level=0;
  - out_valid=0, out_data=0, out_err=0, overflow=0, drop_count=0.
- Reset mid-operation discards all in-flight and buffered results. Digits still emerging from the recomposition chain after reset are ignored, because the delay line is cleared.
- Valid tracking: a RECOMP_LAT-deep shift register carries in_valid. Its tap v_d goes high exactly RECOMP_LAT cycles after in_valid. Back-to-back in_valid every cycle is supported.
- Capture/convert stage, 1 cycle, registered when v_d=1:
  - V = norm_dig_1_[16:0]*MOD0 + norm_dig_0_[15:0], unsigned 33 bits; equivalent to concatenation for MOD0=65536, but implement with parameters.
  - If V >= M/2 (2,560,000,000), S = V - M; otherwise S = V. S is sign-extended to OUT_WIDTH.
- FIFO write happens the cycle after capture. out_data is first-word-fallthrough and registered; out_valid rises the cycle after the write into an empty FIFO.
- Total latency, in_valid to out_valid, is RECOMP_LAT+2 cycles when the FIFO is empty.
- Handshake:
  - A word transfers when out_valid && out_ready.
  - out_data and out_err are held stable while out_valid && !out_ready.
  - out_valid never drops without a transfer (except at reset).
- Full FIFO:
  - A write while full and no read in the same cycle is dropped.
  - On a drop, overflow sets (sticky until reset) and drop_count increments, saturating at 0xFFFF.
  - A simultaneous read and write while full is accepted with no drop; level is unchanged.
- Empty FIFO: out_ready is ignored; no underflow.
- Simultaneous read and write at other levels leave the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- Upstream cannot be stalled: out_ready has no effect on capture timing.

Optional Feature:
- Macro RECOMP_RANGE_CHK_EN.
- Defined:
  - At capture, flag err = (norm_dig_0_ >= MOD0) || (norm_dig_1_ >= MOD1), using the full DATA_WIDTH compare.
  - err is stored in the FIFO alongside the data and presented on out_err with its word.
  - The conversion still uses the truncated digits.
- Not defined: no compare logic; out_err is tied 0; the upper digit bits are ignored.

Test Plan:
- Single op, RECOMP_LAT=18: in_valid at cycle 0 with d0=5, d1=0 at cycle 18 -> out_valid at cycle 20, out_data=5, out_err=0.
- d1=1, d0=0 -> out_data=65536. d1=78124, d0=65535 -> out_data=-1. d1=39062, d0=32768 (V=M/2) -> out_data=-2,560,000,000.
- 20 back-to-back ops with out_ready=0 -> 8 words buffered, fifo_level=8, overflow=1, drop_count=12; then out_ready=1 drains the first 8 in order with no gaps.
- FIFO full, a read and a write in the same cycle -> no drop; level stays 8; the new word appears after the older 7.
- rst_n=0 for 1 cycle while 5 ops are in flight and 3 are buffered -> all outputs 0 next cycle; no stale words emerge afterward.
- RECOMP_RANGE_CHK_EN defined: d0=65536 (bit 16 set), d1=0 -> out_err=1, out_data=0. Macro undefined -> same stimulus gives out_err=0.
